square_seq: RTL and testbench

Sequential shift-add squarer computing `N*N`, the arithmetic inverse of the `sqrt` block. It sits beside `sqrt` on the same start/busy/valid handshake and uses the same operand port naming. Benches use it to round-trip-check `sqrt`, and datapaths use it wherever a small square is needed without a combinational multiplier.

---
 rtl/square_pkg.sv | 10 +
 rtl/square_dp.sv | 19 +
 rtl/square_seq.sv | 100 ++++++++++
 tb/tb_square_seq.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/square_pkg.sv
// Shared types and the reference squaring function for the shift-add squarer.
package square_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} sq_state_t;

    function automatic logic [63:0] sq_ref(input logic [31:0] n);
        return {32'b0, n} * {32'b0, n};
    endfunction

endpackage

// File: rtl/square_dp.sv
// One shift-add step of the squarer: conditional accumulate, then shift both operands.
module square_dp #(
    parameter int NBITS = 5
) (
    input  logic [2*NBITS-1:0] acc,
    input  logic [2*NBITS-1:0] mcand,
    input  logic [NBITS-1:0]   mplier,
    output logic [2*NBITS-1:0] acc_nxt,
    output logic [2*NBITS-1:0] mcand_nxt,
    output logic [NBITS-1:0]   mplier_nxt
);

    always_comb begin
        acc_nxt    = mplier[0] ? (acc + mcand) : acc;
        mcand_nxt  = mcand << 1;
        mplier_nxt = mplier >> 1;
    end

endmodule

// File: rtl/square_seq.sv
// Sequential shift-add squarer (N*N) on a start/busy/valid handshake.
// Optional early exit on zero multiplier: define SQUARE_SEQ_EARLY_EXIT_EN.
module square_seq
    import square_pkg::*;
#(
    parameter int NBITS = 5
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 start_i,
    input  logic [NBITS-1:0]     N,
    output logic                 busy,
    output logic                 valid_o,
    output logic [2*NBITS-1:0]   result_o
);

    localparam int CNT_W = $clog2(NBITS + 1);

    sq_state_t            state, state_nxt;
    logic [2*NBITS-1:0]   acc, mcand;
    logic [NBITS-1:0]     mplier;
    logic [NBITS-1:0]     opnd;
    logic [CNT_W-1:0]     cnt;
    logic [2*NBITS-1:0]   acc_nxt, mcand_nxt;
    logic [NBITS-1:0]     mplier_nxt;
    logic                 accept;
    logic                 last;

    square_dp #(.NBITS(NBITS)) u_dp (
        .acc        (acc),
        .mcand      (mcand),
        .mplier     (mplier),
        .acc_nxt    (acc_nxt),
        .mcand_nxt  (mcand_nxt),
        .mplier_nxt (mplier_nxt)
    );

    assign accept = start_i && (state == IDLE || state == DONE);

`ifdef SQUARE_SEQ_EARLY_EXIT_EN
    // Remaining multiplier bits all zero: further iterations cannot change acc.
    assign last = (cnt == CNT_W'(NBITS - 1)) || (mplier_nxt == '0);
`else
    assign last = (cnt == CNT_W'(NBITS - 1));
`endif

    assign busy    = (state == CALC);
    assign valid_o = (state == DONE);

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CALC;
            CALC:    if (last) state_nxt = DONE;
            DONE:    state_nxt = accept ? CALC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            opnd     <= '0;
            cnt      <= '0;
            result_o <= '0;
        end else if (accept) begin
            acc      <= '0;
            mcand    <= {{NBITS{1'b0}}, N};
            mplier   <= N;
            opnd     <= N;
            cnt      <= '0;
        end else if (state == CALC) begin
            acc      <= acc_nxt;
            mcand    <= mcand_nxt;
            mplier   <= mplier_nxt;
            cnt      <= cnt + 1'b1;
            // The register loads on the DONE entry edge, so it moves only while valid_o is high.
            if (last) begin
                result_o <= acc_nxt;
            end
        end
    end

    assert property (@(posedge clk_i) disable iff (!rstn_i)
        valid_o |-> (result_o == (2*NBITS)'(sq_ref(32'(opnd)))));

    assert property (@(posedge clk_i) disable iff (!rstn_i)
        valid_o |=> !valid_o);

endmodule

// File: tb/tb_square_seq.sv
// Directed self-checking bench for square_seq (NBITS=5); honours SQUARE_SEQ_EARLY_EXIT_EN.
module tb_square_seq;

    localparam int NBITS = 5;

    logic               clk_i;
    logic               rstn_i;
    logic               start_i;
    logic [NBITS-1:0]   N;
    logic               busy;
    logic               valid_o;
    logic [2*NBITS-1:0] result_o;

    int tests;
    int fails;

    square_seq #(.NBITS(NBITS)) dut (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .start_i  (start_i),
        .N        (N),
        .busy     (busy),
        .valid_o  (valid_o),
        .result_o (result_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic int exp_lat(input int n);
`ifdef SQUARE_SEQ_EARLY_EXIT_EN
        int k;
        k = 0;
        for (int i = 0; i < NBITS; i++) if (n[i]) k = i;
        return k + 1;
`else
        return NBITS;
`endif
    endfunction

    // Accept n, then count edges until valid_o; v0/b0 are sampled just after the accept edge.
    task automatic run_op(input int n, output int lat, output logic v0, output logic b0);
        @(negedge clk_i);
        start_i = 1'b1;
        N = NBITS'(n);
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        N = NBITS'($urandom);
        v0 = valid_o;
        b0 = busy;
        lat = 0;
        while (!valid_o && lat < 20) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        start_i = 1'b1;
        N = 5'd7;
        repeat (2) @(posedge clk_i);
        #1;
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++;
        if (valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", valid_o); end
        tests++;
        if (result_o !== 10'd0) begin fails++; $display("FAIL reset_result got %0d want 0", result_o); end
        start_i = 1'b0;
        rstn_i = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        logic v0, b0;
        run_op(16, lat, v0, b0);
        tests++;
        if (b0 !== 1'b1) begin fails++; $display("FAIL basic16_busy got %b want 1", b0); end
        tests++;
        if (lat != 5) begin fails++; $display("FAIL basic16_latency got %0d want 5", lat); end
        tests++;
        if (result_o !== 10'd256) begin fails++; $display("FAIL basic16_result got %0d want 256", result_o); end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL basic16_busy_done got %b want 0", busy); end
        @(posedge clk_i);
        #1;
        tests++;
        if (valid_o !== 1'b0) begin fails++; $display("FAIL basic16_pulse got %b want 0", valid_o); end

        run_op(6, lat, v0, b0);
        tests++;
        if (lat != exp_lat(6)) begin fails++; $display("FAIL basic6_latency got %0d want %0d", lat, exp_lat(6)); end
        tests++;
        if (result_o !== 10'd36) begin fails++; $display("FAIL basic6_result got %0d want 36", result_o); end
        repeat (2) @(posedge clk_i);
        #1;
        tests++;
        if (valid_o !== 1'b0 || result_o !== 10'd36) begin
            fails++; $display("FAIL basic6_hold got valid=%b result=%0d want valid=0 result=36", valid_o, result_o);
        end

        run_op(31, lat, v0, b0);
        tests++;
        if (result_o !== 10'd961 || lat != 5) begin
            fails++; $display("FAIL basic31 got result=%0d lat=%0d want 961 lat 5", result_o, lat);
        end
    endtask

    task automatic test_zero();
        int lat;
        logic v0, b0;
        @(posedge clk_i);
        run_op(0, lat, v0, b0);
        tests++;
        if (result_o !== 10'd0) begin fails++; $display("FAIL zero_result got %0d want 0", result_o); end
        tests++;
`ifdef SQUARE_SEQ_EARLY_EXIT_EN
        if (lat != 1) begin fails++; $display("FAIL zero_latency got %0d want 1", lat); end
`else
        if (lat != 5) begin fails++; $display("FAIL zero_latency got %0d want 5", lat); end
`endif
    endtask

    task automatic test_ignore_start();
        int lat;
        int pulses;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b1;
        N = 5'd3;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        @(negedge clk_i);
        start_i = 1'b1;
        N = 5'd7;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        lat = 1;
        while (!valid_o && lat < 20) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
        tests++;
        if (result_o !== 10'd9 || lat != exp_lat(3)) begin
            fails++; $display("FAIL ignore_result got %0d lat=%0d want 9 lat %0d", result_o, lat, exp_lat(3));
        end
        pulses = 0;
        repeat (8) begin
            @(posedge clk_i);
            #1;
            if (valid_o || busy) pulses++;
        end
        tests++;
        if (pulses != 0) begin fails++; $display("FAIL ignore_not_queued got %0d active cycles want 0", pulses); end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk_i);
        start_i = 1'b1;
        N = 5'd5;
        @(posedge clk_i);
        #1;
        N = 5'd12;
        lat = 0;
        while (!valid_o && lat < 20) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
        tests++;
        if (result_o !== 10'd25 || lat != exp_lat(5)) begin
            fails++; $display("FAIL b2b_first got %0d lat=%0d want 25 lat %0d", result_o, lat, exp_lat(5));
        end
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        tests++;
        if (busy !== 1'b1 || valid_o !== 1'b0) begin
            fails++; $display("FAIL b2b_no_idle got busy=%b valid=%b want busy=1 valid=0", busy, valid_o);
        end
        lat = 0;
        while (!valid_o && lat < 20) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
        tests++;
        if (result_o !== 10'd144 || lat != exp_lat(12)) begin
            fails++; $display("FAIL b2b_second got %0d lat=%0d want 144 lat %0d", result_o, lat, exp_lat(12));
        end
    endtask

    task automatic test_mid_reset();
        int lat;
        int pulses;
        logic v0, b0;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b1;
        N = 5'd20;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b0;
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        tests++;
        if (busy !== 1'b0 || valid_o !== 1'b0 || result_o !== 10'd0) begin
            fails++; $display("FAIL midrst_state got busy=%b valid=%b result=%0d want 0 0 0", busy, valid_o, result_o);
        end
        pulses = 0;
        repeat (8) begin
            @(posedge clk_i);
            #1;
            if (valid_o) pulses++;
        end
        tests++;
        if (pulses != 0) begin fails++; $display("FAIL midrst_no_valid got %0d pulses want 0", pulses); end
        run_op(9, lat, v0, b0);
        tests++;
        if (result_o !== 10'd81 || lat != exp_lat(9)) begin
            fails++; $display("FAIL midrst_after got %0d lat=%0d want 81 lat %0d", result_o, lat, exp_lat(9));
        end
    endtask

    task automatic test_exhaustive();
        int lat;
        logic v0, b0;
        logic [9:0] want;
        for (int n = 0; n < 32; n++) begin
            run_op(n, lat, v0, b0);
            want = 10'(n * n);
            tests++;
            if (result_o !== want || lat != exp_lat(n) || v0 !== 1'b0 || b0 !== 1'b1) begin
                fails++;
                $display("FAIL exh_n%0d got result=%0d lat=%0d v0=%b b0=%b want %0d lat %0d v0=0 b0=1",
                         n, result_o, lat, v0, b0, want, exp_lat(n));
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rstn_i = 1'b0;
        start_i = 1'b0;
        N = '0;
        test_reset();
        test_basic();
        test_zero();
        test_ignore_start();
        test_back_to_back();
        test_mid_reset();
        test_exhaustive();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
